led_mode_ctrl: RTL and testbench
================================

# led_mode_ctrl

Push-button driven LED mode controller for the 4-LED board examples. Synchronizes and debounces one raw push-button and steps a 4-state mode machine on each press: OFF, BLINK, CHASE, COUNT. A shared prescaler sequences the selected pattern onto the LED bank. Sits between the board button pin and the LED pins, replacing free-running blink logic in the top level.

## Interface
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable cycles required to accept a button level (10 ms at 10 MHz); must be at least 1.
- `STEP_CYCLES`, default 2500000: clock cycles per pattern step (250 ms at 10 MHz); must be at least 2.
- `clk`  in  1  system clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `btn`  in  1  raw push-button, active-low (0 = pressed), asynchronous to `clk`.
- `led`  out  4  registered LED drive.
- `mode`  out  2  current mode: 0 OFF, 1 BLINK, 2 CHASE, 3 COUNT.

## Operation
- Synchronizer: two flops on `btn`, both reset to 1.
- Debouncer:
  - Accepted level `btn_db` resets to 1.
  - Counter increments on each edge where the synchronized input differs from `btn_db`, and clears when they match.
  - `btn_db` takes the synchronized value on the `DEBOUNCE_CYCLES`-th consecutive differing edge; the counter clears on the same edge.
- Press detect: registered one-cycle pulse `press` on each 1->0 transition of `btn_db`. Release produces no pulse. A held button produces exactly one pulse.
- Mode FSM:
  - Sequence OFF -> BLINK -> CHASE -> COUNT -> OFF, advancing on `press`.
  - Reset state is OFF.
  - Every mode entry clears the prescaler and reinitializes the pattern.
- Prescaler:
  - Counts 0..`STEP_CYCLES`-1 and wraps.
  - `tick` is high while the count equals `STEP_CYCLES`-1.
  - Width is $clog2(`STEP_CYCLES`).
- Pattern register `pat[3:0]`, entry value then per-tick update:
  - OFF: 0000, held.
  - BLINK: 1111; each tick inverts all bits (1111 <-> 0000).
  - CHASE: 0001; each tick rotates left (1000 -> 0001).
  - COUNT: 0000; each tick increments by 1 modulo 16 (1111 -> 0000).
- `led` = `pat`, or its inversion, as set under Configuration.
- Simultaneous `press` and `tick`: `press` wins. Mode advances, pattern takes its entry value, prescaler goes to 0, and the tick is discarded.
- Reset asserted mid-operation: all state returns immediately to reset values, regardless of button or prescaler state.

## Timing
- Reset values:
  - `mode` = 0.
  - `led` = 0000 (1111 with `LED_ACTIVE_LOW_EN` defined).
  - Synchronizer and `btn_db` = 1.
  - Debounce counter, prescaler and `press` = 0.
- Button latency: `btn` low before edge E0. Then:
  - `btn_db` falls at edge E0+`DEBOUNCE_CYCLES`+1.
  - `press` is high for the cycle after edge E0+`DEBOUNCE_CYCLES`+2.
  - `mode` and `led` show the new mode's entry value after edge E0+`DEBOUNCE_CYCLES`+3.
- A bounce pulse shorter than `DEBOUNCE_CYCLES` cycles, in either direction, causes no level change and no press.
- Step latency:
  - First pattern update occurs `STEP_CYCLES` edges after the mode-entry edge.
  - Later updates occur every `STEP_CYCLES` edges.
- `led` and `mode` are both registered and never glitch.

## Configuration
- `LED_ACTIVE_LOW_EN`:
  - Defined: `led` = ~`pat`, for boards with active-low LEDs; reset value 1111.
  - Undefined: `led` = `pat`; reset value 0000.
- `mode` is unaffected by the macro.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `STEP_CYCLES`=8, macro undefined unless stated.
- Reset:
  - Stimulus: hold `rst`=0 for 20 cycles, then release with `btn`=1 for 100 cycles.
  - Required: `mode`=0 and `led`=0000 throughout.
- Clean press:
  - Stimulus: drive `btn`=0 before edge E0 and hold.
  - Required: `mode`=1 and `led`=1111 exactly after edge E0+7; `led`=0000 after 8 more edges; `mode` stays 1 while held.
- Bounce:
  - Stimulus: pulse `btn` low for 3 cycles, high 2, low 3, then high.
  - Required: `mode` remains 0 and no `press` pulse.
- Full wrap:
  - Stimulus: four clean presses, each held and released for 20 cycles.
  - Required: `mode` 1, 2, 3, 0.
  - Required in CHASE: `led` 0001, 0010, 0100, 1000, 0001 at 8-cycle steps.
  - Required in COUNT after 17 ticks: 0001, having wrapped through 1111 -> 0000.
- Collision and mid-run reset:
  - Stimulus: in COUNT, time a press so `press` coincides with `tick`.
  - Required: `mode`=0, `led`=0000, and the next tick is 8 edges later.
  - Stimulus: assert `rst` low mid-CHASE, asynchronously to `clk`.
  - Required: `led`=0000 and `mode`=0 immediately, without waiting for a clock edge.
- Macro:
  - Stimulus: rerun the reset and clean-press scenarios with `LED_ACTIVE_LOW_EN` defined.
  - Required: `led`=1111 at reset and 0000 on BLINK entry; `mode` sequence identical to the undefined build.

Source files
------------

// File: rtl/led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// led_mode_ctrl
//
// Push-button driven LED mode controller for the 4-LED board examples.
// A raw active-low push-button is synchronized, debounced and edge-detected.
// Each accepted press steps a four-state mode machine:
//     OFF -> BLINK -> CHASE -> COUNT -> OFF
// A shared prescaler paces the selected pattern onto the LED bank.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable cycles needed to accept a new button
//                     level (>= 1)
//   STEP_CYCLES     : clock cycles per pattern step (>= 2)
//
// Ports
//   clk   in   1  system clock, rising edge
//   rst   in   1  asynchronous active-low reset
//   btn   in   1  raw push-button, active-low (0 = pressed), asynchronous
//   led   out  4  registered LED drive
//   mode  out  2  current mode: 0 OFF, 1 BLINK, 2 CHASE, 3 COUNT
//
// Configuration macro
//   LED_ACTIVE_LOW_EN : when defined, led = ~pat (reset value 4'b1111);
//                       otherwise led = pat (reset value 4'b0000).
// -----------------------------------------------------------------------------
module led_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int STEP_CYCLES     = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic [3:0] led,
    output logic [1:0] mode
);

    // Counter of DB_W bits only has to reach DEBOUNCE_CYCLES-1.
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PS_W = $clog2(STEP_CYCLES);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_CYCLES - 1);

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [3:0] LED_RESET = 4'b1111;
`else
    localparam logic [3:0] LED_RESET = 4'b0000;
`endif

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_CHASE = 2'd2,
        MODE_COUNT = 2'd3
    } mode_e;

    logic            sync1_r;
    logic            sync2_r;
    logic            btn_db_r;
    logic [DB_W-1:0] db_cnt_r;
    logic            btn_db_d_r;
    logic            press_r;
    mode_e           state_r;
    logic [PS_W-1:0] presc_r;
    logic [3:0]      pat_r;
    logic            tick_s;

    // Successor mode in the fixed OFF -> BLINK -> CHASE -> COUNT cycle.
    function automatic mode_e next_mode(input mode_e cur);
        mode_e nxt;
        case (cur)
            MODE_OFF:   nxt = MODE_BLINK;
            MODE_BLINK: nxt = MODE_CHASE;
            MODE_CHASE: nxt = MODE_COUNT;
            MODE_COUNT: nxt = MODE_OFF;
            default:    nxt = MODE_OFF;
        endcase
        return nxt;
    endfunction

    // Pattern value loaded when a mode is entered.
    function automatic logic [3:0] entry_pat(input mode_e md);
        logic [3:0] p;
        case (md)
            MODE_OFF:   p = 4'b0000;
            MODE_BLINK: p = 4'b1111;
            MODE_CHASE: p = 4'b0001;
            MODE_COUNT: p = 4'b0000;
            default:    p = 4'b0000;
        endcase
        return p;
    endfunction

    // Pattern value after one prescaler tick in the given mode.
    function automatic logic [3:0] step_pat(input mode_e md, input logic [3:0] cur);
        logic [3:0] p;
        case (md)
            MODE_OFF:   p = 4'b0000;
            MODE_BLINK: p = ~cur;
            MODE_CHASE: p = {cur[2:0], cur[3]};
            MODE_COUNT: p = cur + 4'd1;
            default:    p = 4'b0000;
        endcase
        return p;
    endfunction

    // Map the logical pattern onto the board's LED polarity.
    function automatic logic [3:0] led_drive(input logic [3:0] p);
`ifdef LED_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    assign tick_s = (presc_r == PS_LAST);
    assign mode   = state_r;

    // Two-flop synchronizer for the asynchronous button pin (idle high).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // Debouncer: accept the synchronized level only after it has differed
    // from the accepted level for DEBOUNCE_CYCLES consecutive edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt_r <= {DB_W{1'b0}};
            btn_db_r <= 1'b1;
        end else if (sync2_r != btn_db_r) begin
            if (db_cnt_r == DB_LAST) begin
                btn_db_r <= sync2_r;
                db_cnt_r <= {DB_W{1'b0}};
            end else begin
                db_cnt_r <= db_cnt_r + DB_W'(1);
            end
        end else begin
            db_cnt_r <= {DB_W{1'b0}};
        end
    end

    // Press detector: one-cycle pulse on each 1->0 of the debounced level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_db_d_r <= 1'b1;
            press_r    <= 1'b0;
        end else begin
            btn_db_d_r <= btn_db_r;
            press_r    <= btn_db_d_r & ~btn_db_r;
        end
    end

    // Mode FSM with prescaler and pattern; a press takes priority over a
    // coincident tick, so the new mode always starts from a clean step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= MODE_OFF;
            presc_r <= {PS_W{1'b0}};
            pat_r   <= 4'b0000;
            led     <= LED_RESET;
        end else if (press_r) begin
            state_r <= next_mode(state_r);
            presc_r <= {PS_W{1'b0}};
            pat_r   <= entry_pat(next_mode(state_r));
            led     <= led_drive(entry_pat(next_mode(state_r)));
        end else if (tick_s) begin
            state_r <= state_r;
            presc_r <= {PS_W{1'b0}};
            pat_r   <= step_pat(state_r, pat_r);
            led     <= led_drive(step_pat(state_r, pat_r));
        end else begin
            state_r <= state_r;
            presc_r <= presc_r + PS_W'(1);
            pat_r   <= pat_r;
            led     <= led;
        end
    end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_mode_ctrl
//
// Self-checking bench for led_mode_ctrl with DEBOUNCE_CYCLES=4, STEP_CYCLES=8.
// The reference model tracks only the current mode and the edge on which that
// mode was entered; the expected LED value is derived arithmetically from the
// number of whole steps elapsed since entry. Press timing is predicted from
// the button latency (entry 8 edges after the edge that precedes btn falling).
// -----------------------------------------------------------------------------
module tb_led_mode_ctrl;

    localparam int DB = 4;
    localparam int ST = 8;
    // btn set just after edge N -> E0 = N+1 -> entry edge E0+DB+3.
    localparam int PRESS_LAT = DB + 4;

    logic       clk;
    logic       rst;
    logic       btn;
    logic [3:0] led;
    logic [1:0] mode;

    int cyc;
    int entry_cyc;
    int pending;
    int m;
    int checks;
    int failures;

    led_mode_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .STEP_CYCLES    (ST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .btn (btn),
        .led (led),
        .mode(mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected LED value k edges after entering mode md.
    function automatic logic [3:0] exp_led(input int md, input int k);
        int n;
        logic [3:0] p;
        n = k / ST;
        case (md)
            0:       p = 4'b0000;
            1:       p = ((n % 2) == 0) ? 4'b1111 : 4'b0000;
            2:       p = 4'(1 << (n % 4));
            3:       p = 4'(n % 16);
            default: p = 4'b0000;
        endcase
`ifdef LED_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    task automatic check(input string tag);
        logic [3:0] el;
        logic [1:0] em;
        el = exp_led(m, cyc - entry_cyc);
        em = 2'(m);
        checks++;
        assert (mode === em) else begin
            failures++;
            $error("FAIL %s_mode cyc=%0d got=%0d exp=%0d", tag, cyc, mode, em);
        end
        checks++;
        assert (led === el) else begin
            failures++;
            $error("FAIL %s_led cyc=%0d got=%b exp=%b", tag, cyc, led, el);
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (pending >= 0 && cyc == pending) begin
                m         = (m + 1) % 4;
                entry_cyc = cyc;
                pending   = -1;
            end
            check(tag);
        end
    endtask

    task automatic press_release(input int hold, input int rel, input string tag);
        btn     = 1'b0;
        pending = cyc + PRESS_LAT;
        run(hold, tag);
        btn = 1'b1;
        run(rel, tag);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        entry_cyc = 0;
        pending   = -1;
        m         = 0;
        rst       = 1'b0;
        btn       = 1'b1;

        // Reset held, then released with the button idle.
        run(20, "reset_hold");
        rst = 1'b1;
        entry_cyc = cyc;
        run(100, "reset_idle");

        // Bounce shorter than the debounce window in both directions.
        btn = 1'b0; run(3, "bounce");
        btn = 1'b1; run(2, "bounce");
        btn = 1'b0; run(3, "bounce");
        btn = 1'b1; run(20, "bounce");

        // Clean press: no change up to E0+6, BLINK entry after E0+7.
        btn     = 1'b0;
        pending = cyc + PRESS_LAT;
        run(PRESS_LAT - 1, "press_pre");
        run(1, "press_entry");
        run(ST, "blink_step");
        run(int'($urandom_range(10, 30)), "blink_held");
        btn = 1'b1;
        run(20 + int'($urandom_range(0, 20)), "blink_rel");

        // BLINK -> CHASE, dwell long enough to see a full rotation.
        press_release(int'($urandom_range(12, 20)), 20, "to_chase");
        run(40 + int'($urandom_range(0, 40)), "chase");

        // CHASE -> COUNT, dwell past 17 ticks to see the 1111 -> 0000 wrap.
        press_release(int'($urandom_range(12, 20)), 20, "to_count");
        run(17 * ST + int'($urandom_range(0, 20)), "count");

        // Press aligned so that the press pulse coincides with a tick.
        while (((cyc - entry_cyc) % ST) != 0) run(1, "align");
        press_release(int'($urandom_range(12, 20)), 20, "collide");

        // OFF -> BLINK -> CHASE with a collision on the second press.
        press_release(int'($urandom_range(12, 20)), 20 + int'($urandom_range(0, 15)), "to_blink2");
        while (((cyc - entry_cyc) % ST) != 0) run(1, "align2");
        press_release(int'($urandom_range(12, 20)), 20, "to_chase2");
        run(int'($urandom_range(5, 30)), "chase2");

        // Asynchronous reset mid-CHASE: outputs must clear before any edge.
        #3;
        rst = 1'b0;
        #1;
        m       = 0;
        pending = -1;
        check("async_rst");
        run(5, "async_rst_hold");
        rst = 1'b1;
        entry_cyc = cyc;
        run(20, "post_rst");

        // A final press after reset to confirm normal operation resumes.
        press_release(int'($urandom_range(12, 20)), 20, "resume");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
